// File: rtl/store_reader.sv
// Consumer end of the neuron value-store interface: a small FIFO for sampled
// values, plus a refractory spike generator fed by values leaving the FIFO.
//
// state      | meaning
// IDLE       | a popped value >= THRESHOLD fires a spike
// REFRACTORY | counting down after a spike; pops never fire
module store_reader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int THRESHOLD = 10,
  parameter int REFRACT   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     spike,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(REFRACT + 1);
  localparam logic signed [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

  typedef enum logic {IDLE, REFRACTORY} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  state_t           state_q, state_d;
  logic [RW-1:0]    refr_q, refr_d;
  logic             spike_d;
  logic             fire;

  // Ready comes only from registered occupancy, so a full FIFO never accepts
  // a value even when the head is popped in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out       = out_valid ? mem[rd_ptr] : '0;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign fire = ($signed(out) >= THR);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      refr_q  <= '0;
      spike   <= 1'b0;
    end else begin
      state_q <= state_d;
      refr_q  <= refr_d;
      spike   <= spike_d;
    end
  end

  always_comb begin
    state_d = state_q;
    refr_d  = refr_q;
    spike_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop && fire) begin
          spike_d = 1'b1;
          refr_d  = RW'(REFRACT);
          state_d = REFRACTORY;
        end
      end
      REFRACTORY: begin
        // A pop on the edge that ends the window is still refractory.
        refr_d = refr_q - RW'(1);
        if (refr_q == RW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
